cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle sequencer for the miniRISC core. It steps the datapath through fetch, decode, execute, memory and write-back phases. It issues the phase enables for the instruction register, PC and register file, and runs a request/ready handshake with instruction/data memory. It sits between the combinational instruction decoder, which supplies halt, memory-op and write-back qualifiers from the current IR, and the datapath registers. It also owns run/halt control and the memory-timeout fault.

## Interface
Parameters:
- CNT_W, 16, width of retired-instruction counter ICOUNT
- TIMEOUT, 15, consecutive MEM_RDY-low cycles in FETCH or MEM before FAULT (legal range 1..255)

Ports:
- CLK  in  1  system clock; all state changes on rising edge
- RSTN  in  1  reset; asynchronous, active-low
- START  in  1  run request; honoured only in IDLE and HALT
- HLT  in  1  decoded halt instruction; sampled in DECODE
- MEM_OP  in  2  decoded memory op: 00 none, 01 load, 10 store, 11 reserved (treated as none); sampled in EXEC, MEM and WB
- WB_EN  in  1  decoded register-write qualifier; sampled in WB
- MEM_RDY  in  1  memory ready/ack for the current request
- MEM_REQ  out  1  memory request (fetch or data)
- MEM_WE  out  1  data store strobe, valid with MEM_REQ
- IR_LD  out  1  load instruction register
- PC_EN  out  1  advance PC (one pulse per instruction)
- RF_WE  out  1  register-file write enable
- BUSY  out  1  high in FETCH, DECODE, EXEC, MEM and WB
- HALTED  out  1  high in HALT
- FAULT  out  1  high in FAULT (sticky)
- STATE  out  3  current state code
- ICOUNT  out  CNT_W  retired-instruction count

## Operation
- State codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
- IDLE: START=1 -> FETCH. Otherwise stay.
- FETCH: MEM_REQ=1, MEM_WE=0.
  - MEM_RDY=1: IR_LD=1 in the same cycle (combinational), then -> DECODE.
  - MEM_RDY=0: wait counter increments.
- DECODE: HLT=1 -> HALT. Otherwise -> EXEC.
- EXEC: MEM_OP of 01 or 10 -> MEM. Otherwise -> WB.
- MEM: MEM_REQ=1, MEM_WE=(MEM_OP==10).
  - MEM_RDY=1 -> WB.
  - MEM_RDY=0: wait counter increments.
- WB:
  - PC_EN=1 and RF_WE=WB_EN&(MEM_OP!=10), both combinational, single cycle.
  - ICOUNT increments, wrapping modulo 2^CNT_W.
  - Next state: FETCH.
- HALT: HALTED=1; PC is not advanced past the halt instruction. START=1 asserts PC_EN in that cycle (skipping the halt) and goes to FETCH.
- FAULT: entered from FETCH or MEM when MEM_RDY has been low for TIMEOUT consecutive cycles, i.e. on the edge ending the TIMEOUT-th low cycle.
  - FAULT=1, and the block stays in FAULT until RSTN.
  - START is ignored in FAULT.
- Wait counter:
  - Cleared on entry to FETCH or MEM, and on any cycle where MEM_RDY=1.
  - MEM_RDY=1 in the TIMEOUT-th cycle wins over the fault: the normal transition is taken.
- START outside IDLE or HALT is ignored. HLT outside DECODE is ignored.
- Reset (asynchronous, including mid-instruction or mid-handshake):
  - Goes to IDLE; wait counter=0; ICOUNT=0.
  - All outputs 0, except STATE=0.
  - An abandoned memory request is simply dropped.

## Timing
- STATE, MEM_REQ, MEM_WE, BUSY, HALTED and FAULT are Moore outputs, decoded from the state register.
- IR_LD, PC_EN and RF_WE are Mealy outputs.
- Zero-wait memory:
  - ALU or branch instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load or store: 5 cycles.
  - Each MEM_RDY-low cycle adds one cycle.
- PC_EN and ICOUNT update on the same edge that leaves WB. Next FETCH is the cycle after WB.
- START to first MEM_REQ: 1 cycle.
- HLT in DECODE to HALTED=1: 1 cycle.

## Structure
- Shared package miniRISC_pkg holds:
  - state codes (3-bit localparams or enum)
  - MEM_OP codes MOP_NONE/MOP_LOAD/MOP_STORE
- One sub-module: mem_wait_timer.
  - Holds an 8-bit saturating counter.
  - Inputs: clear and count; output: expired (count==TIMEOUT).
  - Parameterised by TIMEOUT; shared by the FETCH and MEM phases.
- Top level holds the state register, next-state logic, output decode and the ICOUNT register.

## Test plan
- Reset, START pulse, 3 ALU instructions with MEM_RDY tied 1 -> 12 cycles; ICOUNT=3; exactly 3 PC_EN and 3 RF_WE pulses, each in WB.
- Load (MEM_OP=01, WB_EN=1) with MEM_RDY low 2 cycles in MEM -> 7 cycles; MEM_WE=0 throughout; RF_WE=1 in WB. Store (10) -> MEM_WE=1 in MEM, RF_WE=0 in WB.
- HLT=1 in DECODE -> HALT after 1 cycle, HALTED=1, no PC_EN. START -> PC_EN for 1 cycle, then FETCH; ICOUNT unchanged by the halt.
- TIMEOUT=15, MEM_RDY held low in FETCH -> FAULT after exactly 15 cycles; START ignored afterwards. Repeat with MEM_RDY=1 on cycle 15 -> DECODE, no fault.
- RSTN low mid-MEM with MEM_REQ=1 -> immediately IDLE, all outputs 0, ICOUNT=0, without waiting for a clock edge.
- CNT_W=4: 16 instructions retired -> ICOUNT wraps to 0; MEM_OP=11 -> no MEM phase, treated as none.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
// miniRISC_pkg: sequencer state codes and memory-op encodings shared across the core.
package miniRISC_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_e;
  localparam logic [1:0] MOP_NONE  = 2'b00;
  localparam logic [1:0] MOP_LOAD  = 2'b01;
  localparam logic [1:0] MOP_STORE = 2'b10;
endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: decoder qualifiers, memory handshake and datapath enables of the sequencer.
interface cpu_sequencer_if #(parameter int CNT_W = 16);
  logic             START;
  logic             HLT;
  logic [1:0]       MEM_OP;
  logic             WB_EN;
  logic             MEM_RDY;
  logic             MEM_REQ;
  logic             MEM_WE;
  logic             IR_LD;
  logic             PC_EN;
  logic             RF_WE;
  logic             BUSY;
  logic             HALTED;
  logic             FAULT;
  logic [2:0]       STATE;
  logic [CNT_W-1:0] ICOUNT;
  modport master (
    input  START, HLT, MEM_OP, WB_EN, MEM_RDY,
    output MEM_REQ, MEM_WE, IR_LD, PC_EN, RF_WE, BUSY, HALTED, FAULT, STATE, ICOUNT
  );
  modport slave (
    output START, HLT, MEM_OP, WB_EN, MEM_RDY,
    input  MEM_REQ, MEM_WE, IR_LD, PC_EN, RF_WE, BUSY, HALTED, FAULT, STATE, ICOUNT
  );
endinterface

// File: rtl/cpu_sequencer_mem_wait_timer.sv
// mem_wait_timer: saturating count of MEM_RDY-low cycles; expired flags the TIMEOUT-th low cycle.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = clear_i ? 8'd0 : (count_i && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt_q <= 8'd0;
    else          cnt_q <= cnt_d;
  // cnt_q holds completed low cycles, so the current low cycle is number cnt_q+1
  assign expired_o = count_i && cnt_q == LAST;
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/exec/mem/wb sequencer with run/halt control
// and a sticky memory-timeout fault.
module cpu_sequencer
  import miniRISC_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic            CLK,
  input  logic            RSTN,
  cpu_sequencer_if.master bus
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] icount_q, icount_d;
  logic             waiting, expired;
  logic             is_mem_op;
  assign is_mem_op = bus.MEM_OP == MOP_LOAD || bus.MEM_OP == MOP_STORE;
  assign waiting   = (state_q == S_FETCH || state_q == S_MEM) && !bus.MEM_RDY;
  // any non-waiting cycle clears, which covers entry into FETCH/MEM and every ready cycle
  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i     (CLK),
    .rst_n_i   (RSTN),
    .clear_i   (!waiting),
    .count_i   (waiting),
    .expired_o (expired)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = bus.START ? S_FETCH : S_IDLE;
      S_FETCH:  state_d = bus.MEM_RDY ? S_DECODE : expired ? S_FAULT : S_FETCH;
      S_DECODE: state_d = bus.HLT ? S_HALT : S_EXEC;
      S_EXEC:   state_d = is_mem_op ? S_MEM : S_WB;
      S_MEM:    state_d = bus.MEM_RDY ? S_WB : expired ? S_FAULT : S_MEM;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = bus.START ? S_FETCH : S_HALT;
      default:  state_d = S_FAULT;
    endcase
  end
  assign icount_d = icount_q + CNT_W'(state_q == S_WB);
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      state_q  <= S_IDLE;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      icount_q <= icount_d;
    end
  assign bus.STATE   = state_q;
  assign bus.MEM_REQ = state_q == S_FETCH || state_q == S_MEM;
  assign bus.MEM_WE  = state_q == S_MEM && bus.MEM_OP == MOP_STORE;
  assign bus.BUSY    = state_q inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB};
  assign bus.HALTED  = state_q == S_HALT;
  assign bus.FAULT   = state_q == S_FAULT;
  assign bus.ICOUNT  = icount_q;
  assign bus.IR_LD   = state_q == S_FETCH && bus.MEM_RDY;
  assign bus.PC_EN   = state_q == S_WB || (state_q == S_HALT && bus.START);
  assign bus.RF_WE   = state_q == S_WB && bus.WB_EN && bus.MEM_OP != MOP_STORE;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: random run of the sequencer against a phase-level reference model.
module tb_cpu_sequencer;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 15;
  logic CLK = 1'b0;
  logic RSTN = 1'b0;
  int   checks = 0;
  int   failures = 0;
  cpu_sequencer_if #(.CNT_W(CNT_W)) bus ();
  cpu_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (.CLK(CLK), .RSTN(RSTN), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask
  // phase numbers: 0 idle,1 fetch,2 decode,3 exec,4 mem,5 wb,6 halt,7 fault
  int m_st = 0, m_wait = 0, m_ic = 0;
  function automatic logic [31:0] pack_out(input int st, input bit req, we, ir, pc, rf);
    bit busy = st >= 1 && st <= 5;
    return {21'd0, 3'(st), req, we, ir, pc, rf, busy, st == 6, st == 7};
  endfunction
  function automatic logic [31:0] dut_out();
    return {21'd0, bus.STATE, bus.MEM_REQ, bus.MEM_WE, bus.IR_LD, bus.PC_EN, bus.RF_WE,
            bus.BUSY, bus.HALTED, bus.FAULT};
  endfunction
  task automatic check_reset(input string tag);
    chk({tag, "_out"}, dut_out(), 32'd0);
    chk({tag, "_icount"}, 32'(bus.ICOUNT), 32'd0);
  endtask
  initial begin
    int low_run = 0;
    int fault_age = 0;
    {bus.START, bus.HLT, bus.MEM_OP, bus.WB_EN, bus.MEM_RDY} = '0;
    #1 check_reset("por");
    @(posedge CLK); #1;
    RSTN = 1'b1;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      bit mid_mem = m_st == 4 && $urandom_range(0, 39) == 0;
      if (mid_mem || $urandom_range(0, 399) == 0 || fault_age > 5) begin
        RSTN = 1'b0;
        #1 check_reset(mid_mem ? "rst_mid_mem" : "rst_async");
        m_st = 0; m_wait = 0; m_ic = 0; fault_age = 0; low_run = 0;
        @(posedge CLK); #1;
        chk("rst_held_state", 32'(bus.STATE), 32'd0);
        RSTN = 1'b1;
        continue;
      end
      begin
        bit start, hlt, wben, rdy;
        logic [1:0] mop;
        int nst;
        bit req, we, ir, pc, rf;
        start = $urandom_range(0, 3) == 0;
        hlt   = $urandom_range(0, 9) == 0;
        wben  = $urandom_range(0, 1) == 1;
        mop   = 2'($urandom_range(0, 3));
        if (low_run == 0 && $urandom_range(0, 29) == 0) low_run = $urandom_range(13, 17);
        if (low_run > 0) begin
          rdy = 1'b0;
          low_run--;
        end else rdy = $urandom_range(0, 4) != 0;
        bus.START = start; bus.HLT = hlt; bus.MEM_OP = mop; bus.WB_EN = wben; bus.MEM_RDY = rdy;
        req = m_st == 1 || m_st == 4;
        we  = m_st == 4 && mop == 2'b10;
        ir  = m_st == 1 && rdy;
        pc  = m_st == 5 || (m_st == 6 && start);
        rf  = m_st == 5 && wben && mop != 2'b10;
        #2;
        chk("outputs", dut_out(), pack_out(m_st, req, we, ir, pc, rf));
        chk("icount", 32'(bus.ICOUNT), 32'(m_ic));
        case (m_st)
          0: nst = start ? 1 : 0;
          1: nst = rdy ? 2 : (m_wait + 1 == TIMEOUT) ? 7 : 1;
          2: nst = hlt ? 6 : 3;
          3: nst = (mop == 2'b01 || mop == 2'b10) ? 4 : 5;
          4: nst = rdy ? 5 : (m_wait + 1 == TIMEOUT) ? 7 : 4;
          5: nst = 1;
          6: nst = start ? 1 : 6;
          default: nst = 7;
        endcase
        if (m_st == 5) m_ic = (m_ic + 1) % (1 << CNT_W);
        m_wait = (nst == m_st && (m_st == 1 || m_st == 4)) ? m_wait + 1 : 0;
        m_st = nst;
        if (m_st == 7) fault_age++;
        @(posedge CLK); #1;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
